data_mem_master: RTL and testbench
==================================

DATA_MEM_MASTER -- requirements
Module: data_mem_master

Interface
REQ-001 Parameter: WORD_SIZE, 16, width of address and data.
REQ-002 Parameter: STALL_COUNT, 4, memory access latency in cycles; must equal `MEM_STALL_COUNT.
REQ-003 Clock port: clk, input, 1 bit, single clock; every register updates on its rising edge.
REQ-004 Reset port: reset_n, input, 1 bit, asynchronous, active-low.
REQ-005 req_valid, input, 1 bit: CPU-side request present.
REQ-006 req_write, input, 1 bit: 1 means write, 0 means read; qualified by req_valid.
REQ-007 req_addr, input, WORD_SIZE bits: word address.
REQ-008 req_wdata, input, WORD_SIZE bits: write data.
REQ-009 req_ready, output, 1 bit: master can accept a request this cycle.
REQ-010 resp_valid, output, 1 bit: one-cycle completion pulse.
REQ-011 resp_rdata, output, WORD_SIZE bits: read result, valid while resp_valid=1.
REQ-012 read_m2, output, 1 bit: memory data-port read strobe.
REQ-013 write_m2, output, 1 bit: memory data-port write strobe.
REQ-014 address2, output, WORD_SIZE bits: memory data-port address.
REQ-015 data2, inout, WORD_SIZE bits: bidirectional memory data bus.

Function
REQ-016 The master SHALL be an FSM with states IDLE, READ, WRITE and DONE.
REQ-017 req_ready SHALL be 1 only in IDLE; a request SHALL be accepted on the edge where state=IDLE and req_valid=1.
REQ-018 On accept, the master SHALL latch req_addr, req_wdata and req_write, then move to READ or WRITE; later changes on req_* SHALL be ignored until the next accept.
REQ-019 address2 SHALL hold the latched address, unchanged, for the whole READ or WRITE state.
REQ-020 READ: read_m2 SHALL be 1 for exactly STALL_COUNT+1 consecutive cycles; an internal counter runs 0..STALL_COUNT; data2 SHALL be captured into resp_rdata on the edge ending counter=STALL_COUNT; then go to DONE.
REQ-021 WRITE: write_m2 SHALL be 1 for exactly STALL_COUNT consecutive cycles; then go to DONE.
REQ-022 data2 SHALL be driven with the latched wdata only while write_m2=1, and SHALL be high-impedance at all other times.
REQ-023 read_m2 and write_m2 SHALL never be 1 in the same cycle.
REQ-024 DONE: resp_valid SHALL be 1 for exactly one cycle; the next state SHALL be IDLE.
REQ-025 resp_rdata SHALL hold its last captured value outside READ completion, and SHALL not change after a write.
REQ-026 The counter SHALL clear to 0 on every entry to READ or WRITE.

Reset
REQ-027 While reset_n=0, asynchronously: state=IDLE, counter=0, read_m2=0, write_m2=0, address2=0, resp_valid=0, resp_rdata=0, data2 high-impedance, req_ready=1.
REQ-028 A reset asserted mid-access SHALL abort that access; no resp_valid SHALL follow it.

Configuration
REQ-029 With macro LAST_READ_BUFFER_EN defined, the master SHALL keep a one-entry buffer {valid, addr, data}; valid clears on reset.
REQ-030 With the buffer, a read accepted with valid=1 and addr match SHALL go directly to DONE with the buffered data, without asserting read_m2; a completed memory read SHALL load the buffer; a write to a matching address SHALL update buffer data to the written value.
REQ-031 Without LAST_READ_BUFFER_EN, every read SHALL access memory as in REQ-020.

Verification (STALL_COUNT=4, Memory model attached)
REQ-032 Hold reset_n=0 -> read_m2=0, write_m2=0, resp_valid=0, req_ready=1, data2=Z.
REQ-033 Read 0x0001 (mem=0x0001) -> read_m2 high 5 cycles with address2=0x0001, then one resp_valid with resp_rdata=0x0001, then req_ready=1.
REQ-034 Write 0x1234 to 0x0040, then read 0x0040 -> write_m2 high 4 cycles with data2=0x1234; the read returns 0x1234; read_m2 and write_m2 are never high together.
REQ-035 Read 0x0002, change req_addr to 0x0003 during READ -> address2 stays 0x0002; resp_rdata=0xFFFF.
REQ-036 Drop reset_n in the 2nd READ cycle -> read_m2 falls without waiting for a clock edge; no resp_valid follows; the next request completes normally.
REQ-037 With LAST_READ_BUFFER_EN, read 0x0002 twice -> the second read shows no read_m2 and resp_valid in the cycle after accept with data 0xFFFF; write 0x5555 to 0x0002, then read -> 0x5555 from the buffer.

Source files
------------

// File: rtl/data_mem_master.sv
// data_mem_master: serialises CPU requests onto a stalled memory port with a tristate data bus.
// Latency: read STALL_COUNT+2 cycles accept->resp_valid, write STALL_COUNT+1 (buffer hit: 1).
// Backpressure: req_ready is low while an access is in flight; optional LAST_READ_BUFFER_EN buffer.
`ifndef MEM_STALL_COUNT
`define MEM_STALL_COUNT 4
`endif

module data_mem_master #(
  parameter int WORD_SIZE   = 16,
  parameter int STALL_COUNT = `MEM_STALL_COUNT
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 req_valid,
  input  logic                 req_write,
  input  logic [WORD_SIZE-1:0] req_addr,
  input  logic [WORD_SIZE-1:0] req_wdata,
  output logic                 req_ready,
  output logic                 resp_valid,
  output logic [WORD_SIZE-1:0] resp_rdata,
  output logic                 read_m2,
  output logic                 write_m2,
  output logic [WORD_SIZE-1:0] address2,
  inout  wire  [WORD_SIZE-1:0] data2
);

  localparam int CW = (STALL_COUNT < 1) ? 1 : $clog2(STALL_COUNT + 1);
  localparam logic [CW-1:0] RD_LAST = CW'(STALL_COUNT);
  localparam logic [CW-1:0] WR_LAST = CW'(STALL_COUNT - 1);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [WORD_SIZE-1:0] addr_q;
  logic [WORD_SIZE-1:0] wdata_q;
  logic [WORD_SIZE-1:0] rdata_q;
  logic                 accept;
  logic                 rd_done;
  logic                 buf_hit;
  logic [WORD_SIZE-1:0] buf_dat;

  assign accept  = (state_q == IDLE) && req_valid;
  assign rd_done = (state_q == READ) && (cnt_q == RD_LAST);

`ifdef LAST_READ_BUFFER_EN
  logic                 buf_vld;
  logic [WORD_SIZE-1:0] buf_addr;

  assign buf_hit = buf_vld && (buf_addr == req_addr);

  // Writes to the buffered address keep the buffer coherent with memory.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      buf_vld  <= 1'b0;
      buf_addr <= '0;
      buf_dat  <= '0;
    end else if (rd_done) begin
      buf_vld  <= 1'b1;
      buf_addr <= addr_q;
      buf_dat  <= data2;
    end else if (accept && req_write && buf_hit) begin
      buf_dat  <= req_wdata;
    end
  end
`else
  assign buf_hit = 1'b0;
  assign buf_dat = '0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          cnt_d = '0;
          if (req_write)
            state_d = WRITE;
          else if (buf_hit)
            state_d = DONE;
          else
            state_d = READ;
        end
      end
      READ: begin
        if (cnt_q == RD_LAST)
          state_d = DONE;
        else
          cnt_d = cnt_q + CW'(1);
      end
      WRITE: begin
        if (cnt_q == WR_LAST)
          state_d = DONE;
        else
          cnt_d = cnt_q + CW'(1);
      end
      DONE: state_d = IDLE;
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Request fields are captured only at accept, so later req_* wiggles are ignored.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        if (!req_write && buf_hit)
          rdata_q <= buf_dat;
      end
      if (rd_done)
        rdata_q <= data2;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == DONE);
  assign read_m2    = (state_q == READ);
  assign write_m2   = (state_q == WRITE);
  assign address2   = addr_q;
  assign resp_rdata = rdata_q;
  assign data2      = write_m2 ? wdata_q : {WORD_SIZE{1'bz}};

endmodule

// File: tb/tb_data_mem_master.sv
// Scoreboarded bench for data_mem_master with an attached word memory on the tristate bus.
// Define LAST_READ_BUFFER_EN for both bench and RTL to exercise the last-read buffer.
module tb_data_mem_master;

  localparam int W     = 16;
  localparam int STALL = 4;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_write = 1'b0;
  logic [W-1:0] req_addr = '0;
  logic [W-1:0] req_wdata = '0;
  logic         req_ready, resp_valid, read_m2, write_m2;
  logic [W-1:0] resp_rdata, address2;
  wire  [W-1:0] data2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic         wr;
    logic         hit;
    logic [W-1:0] addr;
    logic [W-1:0] wdata;
    logic [W-1:0] rdata;
    int           due;
  } item_t;

  item_t        sb[$];
  logic [W-1:0] mem     [256];
  logic [W-1:0] ref_mem [256];
  logic [W-1:0] ref_last = '0;
  logic         ref_bv = 1'b0;
  logic [W-1:0] ref_ba = '0;

  data_mem_master #(.WORD_SIZE(W), .STALL_COUNT(STALL)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .read_m2(read_m2), .write_m2(write_m2), .address2(address2), .data2(data2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory: drives the bus while read_m2 is high, stores the bus while write_m2 is high.
  assign data2 = read_m2 ? mem[address2[7:0]] : {W{1'bz}};
  always @(posedge clk) if (write_m2) mem[address2[7:0]] <= data2;

  function automatic logic [W-1:0] init_val(input int i);
    if (i == 1) return 16'h0001;
    if (i == 2) return 16'hFFFF;
    return W'(i * 16'h0101) ^ 16'hA5C3;
  endfunction

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  int rd_run = 0;
  int wr_run = 0;

  always @(negedge clk) begin
    item_t it;
    if (!reset_n) begin
      rd_run = 0;
      wr_run = 0;
    end else begin
      chk("strobe_overlap", {31'd0, read_m2 & write_m2}, 32'd0);
      if (read_m2) rd_run++;
      else if (rd_run > 0) begin
        chk("read_strobe_len", rd_run, STALL + 1);
        rd_run = 0;
      end
      if (write_m2) wr_run++;
      else if (wr_run > 0) begin
        chk("write_strobe_len", wr_run, STALL);
        wr_run = 0;
      end
      if (read_m2 || write_m2) begin
        if (sb.size() == 0) chk("strobe_without_request", 32'd1, 32'd0);
        else begin
          chk("address2", address2, sb[0].addr);
          if (read_m2) chk("read_strobe_for_memory_read", {31'd0, sb[0].wr | sb[0].hit}, 32'd0);
          if (write_m2) begin
            chk("write_strobe_for_write", {31'd0, sb[0].wr}, 32'd1);
            chk("data2_write", data2, sb[0].wdata);
          end
        end
      end
      if (resp_valid) begin
        if (sb.size() == 0) chk("unexpected_resp_valid", 32'd1, 32'd0);
        else begin
          it = sb.pop_front();
          chk("resp_cycle", cyc, it.due);
          chk(it.wr ? "resp_rdata_after_write" : "resp_rdata_read", resp_rdata, it.rdata);
        end
      end
    end
  end

  task automatic issue(input logic wr, input logic [W-1:0] addr, input logic [W-1:0] wd);
    item_t it;
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd;
    n = 0;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      chk("req_ready_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
      return;
    end
    it.wr = wr; it.addr = addr; it.wdata = wd; it.hit = 1'b0;
    if (wr) begin
      ref_mem[addr[7:0]] = wd;
      it.rdata = ref_last;
      it.due   = cyc + 1 + STALL;
    end else begin
`ifdef LAST_READ_BUFFER_EN
      it.hit = ref_bv && (ref_ba == addr);
`endif
      it.rdata = ref_mem[addr[7:0]];
      ref_last = it.rdata;
      it.due   = it.hit ? cyc + 1 : cyc + 2 + STALL;
      ref_bv   = 1'b1;
      ref_ba   = addr;
    end
    sb.push_back(it);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_write = 1'($urandom);
    req_addr  = W'($urandom);
    req_wdata = W'($urandom);
  endtask

  task automatic reset_mid_read(input logic [W-1:0] addr);
    issue(1'b0, addr, '0);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("abort_read_m2_async", {31'd0, read_m2}, 32'd0);
    chk("abort_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("abort_req_ready", {31'd0, req_ready}, 32'd1);
    sb.delete();
    ref_last = '0;
    ref_bv   = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    int n;
    logic         wr;
    logic [W-1:0] a;
    for (int i = 0; i < 256; i++) begin
      mem[i]     <= init_val(i);
      ref_mem[i]  = init_val(i);
    end
    #1;
    chk("reset_read_m2", {31'd0, read_m2}, 32'd0);
    chk("reset_write_m2", {31'd0, write_m2}, 32'd0);
    chk("reset_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("reset_req_ready", {31'd0, req_ready}, 32'd1);
    chk("reset_resp_rdata", resp_rdata, 32'd0);
    chk("reset_address2", address2, 32'd0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    issue(1'b0, 16'h0001, '0);
    issue(1'b1, 16'h0040, 16'h1234);
    issue(1'b0, 16'h0040, '0);
    issue(1'b0, 16'h0002, '0);
    issue(1'b0, 16'h0002, '0);
    issue(1'b1, 16'h0002, 16'h5555);
    issue(1'b0, 16'h0002, '0);
    reset_mid_read(16'h0003);
    issue(1'b1, 16'h0005, 16'hBEEF);
    issue(1'b0, 16'h0005, '0);

    for (int k = 0; k < 150; k++) begin
      wr = ($urandom_range(0, 2) == 0);
      a  = ($urandom_range(0, 4) == 0) ? 16'h0040 : W'($urandom_range(0, 15));
      issue(wr, a, W'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    n = 0;
    while (sb.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() > 0) chk("drain_timeout", sb.size(), 32'd0);
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
